rv32i_mc_control_fsm: RTL and testbench

Main control state machine for the RV32I multi-cycle, unpipelined core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the instruction register load enable, PC update, memory request handshake, register-file write and datapath mux selects. It sits between unified memory, the instruction register outputs (opcode field) and the datapath.

---
 rtl/rv32i_mc_pkg.sv | 51 +++++
 rtl/rv32i_mc_control_fsm.sv | 141 ++++++++++++++
 tb/tb_rv32i_mc_control_fsm.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_mc_pkg.sv
// Shared constants for the RV32I multi-cycle core: opcodes, control FSM
// states, datapath select encodings and the opcode dispatch helper.
package rv32i_mc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_UPPER, S_ALUWB, S_JAL, S_JALR, S_JAL_LINK,
    S_BRANCH, S_TRAP
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic state_t decode_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_op = S_MEMADR;
      OP_R:              decode_op = S_EXEC_R;
      OP_I:              decode_op = S_EXEC_I;
      OP_JAL:            decode_op = S_JAL;
      OP_JALR:           decode_op = S_JALR;
      OP_BRANCH:         decode_op = S_BRANCH;
      OP_LUI, OP_AUIPC:  decode_op = S_UPPER;
      default:           decode_op = S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mc_control_fsm.sv
// Main control FSM of the RV32I multi-cycle core: sequences fetch, decode,
// execute, memory and writeback, one instruction at a time.
module rv32i_mc_control_fsm
  import rv32i_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRwrite,
  output logic       PCwrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       trap
);

  state_t state, state_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nx;
  end

  // Decode is qualified by rst so nothing fires while reset is held.
  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRwrite   = 1'b0;
    PCwrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    trap      = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          if (mem_ready) begin
            IRwrite  = 1'b1;
            PCwrite  = 1'b1;
            state_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_IMM;
          state_nx = decode_op(opcode);
        end
        // The IR holds the opcode stable after fetch, so later states may reuse it.
        S_MEMADR: begin
          ALUSrcA  = SRCA_RS1;
          ALUSrcB  = SRCB_IMM;
          state_nx = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
          if (mem_ready) state_nx = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = RES_MEM;
          RegWrite  = 1'b1;
          state_nx  = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          if (mem_ready) state_nx = S_FETCH;
        end
        S_EXEC_R: begin
          ALUSrcA  = SRCA_RS1;
          ALUSrcB  = SRCB_RS2;
          ALUOp    = ALUOP_FUNCT;
          state_nx = S_ALUWB;
        end
        S_EXEC_I: begin
          ALUSrcA  = SRCA_RS1;
          ALUSrcB  = SRCB_IMM;
          ALUOp    = ALUOP_FUNCT;
          state_nx = S_ALUWB;
        end
        S_UPPER: begin
          ALUSrcA  = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
          ALUSrcB  = SRCB_IMM;
          state_nx = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          state_nx = S_FETCH;
        end
        // Target was left in ALUOut by decode; ALU meanwhile forms the link.
        S_JAL: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          PCwrite  = 1'b1;
          state_nx = S_ALUWB;
        end
        S_JALR: begin
          ALUSrcA   = SRCA_RS1;
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALU;
          PCwrite   = 1'b1;
          state_nx  = S_JAL_LINK;
        end
        S_JAL_LINK: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          state_nx = S_ALUWB;
        end
        S_BRANCH: begin
          ALUSrcA  = SRCA_RS1;
          ALUSrcB  = SRCB_RS2;
          ALUOp    = ALUOP_BR;
          PCwrite  = branch_taken;
          state_nx = S_FETCH;
        end
        S_TRAP: begin
          trap     = 1'b1;
          state_nx = S_TRAP;
        end
        default: state_nx = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_control_fsm.sv
// Directed cycle-by-cycle check of the control FSM outputs against
// hand-written expected control vectors.
module tb_rv32i_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc, IRwrite, PCwrite, RegWrite, trap;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRwrite(IRwrite), .PCwrite(PCwrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .trap(trap)
  );

  // {mem_req, MemWrite, AdrSrc, IRwrite, PCwrite, RegWrite, A, B, op, res, trap}
  localparam logic [14:0] V_ZERO   = 15'h0;
  localparam logic [14:0] V_FRDY   = {6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] V_FWAIT  = {6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] V_DEC    = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_EXR    = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_EXI    = {6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_ALUWB  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MEMADR = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MEMRD  = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MEMWB  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
  localparam logic [14:0] V_MEMWR  = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_BR0    = {6'b000000, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_BR1    = {6'b000010, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_JAL    = {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_JALR   = {6'b000010, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] V_LINK   = {6'b000000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_LUI    = {6'b000000, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_AUIPC  = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_TRAP   = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  // Enables and trap only; selects are don't-care while fetch is stalled.
  localparam logic [14:0] M_CTL    = 15'h7E01;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011,
                         ADDI = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111,
                         BEQ = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %015b expected %015b", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, compare outputs 1ns later.
  task automatic cyc(input string tag, input logic r, input logic [6:0] opc,
                     input logic rdy, input logic bt, input logic [14:0] exp,
                     input logic full = 1'b1);
    logic [14:0] got;
    @(negedge clk);
    rst = r; opcode = opc; mem_ready = rdy; branch_taken = bt;
    #1;
    got = {mem_req, MemWrite, AdrSrc, IRwrite, PCwrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, trap};
    if (full) chk(tag, got, exp);
    else      chk(tag, got & M_CTL, exp & M_CTL);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++)
      cyc($sformatf("reset.%0d", i), 1'b0, 7'($urandom), 1'($urandom), 1'($urandom), V_ZERO);

    // ADD: FETCH, DECODE, EXEC_R, ALUWB
    cyc("add.fetch",  1, ADD, 1, 0, V_FRDY);
    cyc("add.decode", 1, ADD, 1, 0, V_DEC);
    cyc("add.exec",   1, ADD, 1, 0, V_EXR);
    cyc("add.wb",     1, ADD, 1, 0, V_ALUWB);

    // LW with 3 fetch stalls and 2 memory stalls: 10 cycles
    for (int i = 0; i < 3; i++) cyc($sformatf("lw.fwait%0d", i), 1, LW, 0, 0, V_FWAIT, 1'b0);
    cyc("lw.fetch",  1, LW, 1, 0, V_FRDY);
    cyc("lw.decode", 1, LW, 0, 0, V_DEC);
    cyc("lw.memadr", 1, LW, 1, 0, V_MEMADR);
    cyc("lw.rwait0", 1, LW, 0, 0, V_MEMRD);
    cyc("lw.rwait1", 1, LW, 0, 0, V_MEMRD);
    cyc("lw.read",   1, LW, 1, 0, V_MEMRD);
    cyc("lw.wb",     1, LW, 1, 0, V_MEMWB);

    // BEQ not taken, then taken
    cyc("beq0.fetch",  1, BEQ, 1, 1, V_FRDY);
    cyc("beq0.decode", 1, BEQ, 1, 1, V_DEC);
    cyc("beq0.branch", 1, BEQ, 1, 0, V_BR0);
    cyc("beq1.fetch",  1, BEQ, 1, 0, V_FRDY);
    cyc("beq1.decode", 1, BEQ, 1, 0, V_DEC);
    cyc("beq1.branch", 1, BEQ, 1, 1, V_BR1);

    cyc("jal.fetch",  1, JAL, 1, 0, V_FRDY);
    cyc("jal.decode", 1, JAL, 1, 0, V_DEC);
    cyc("jal.jump",   1, JAL, 1, 0, V_JAL);
    cyc("jal.wb",     1, JAL, 1, 0, V_ALUWB);

    cyc("jalr.fetch",  1, JALR, 1, 0, V_FRDY);
    cyc("jalr.decode", 1, JALR, 1, 0, V_DEC);
    cyc("jalr.jump",   1, JALR, 1, 0, V_JALR);
    cyc("jalr.link",   1, JALR, 1, 0, V_LINK);
    cyc("jalr.wb",     1, JALR, 1, 0, V_ALUWB);

    cyc("lui.fetch",  1, LUI, 1, 0, V_FRDY);
    cyc("lui.decode", 1, LUI, 1, 0, V_DEC);
    cyc("lui.upper",  1, LUI, 1, 0, V_LUI);
    cyc("lui.wb",     1, LUI, 1, 0, V_ALUWB);

    cyc("auipc.fetch",  1, AUIPC, 1, 0, V_FRDY);
    cyc("auipc.decode", 1, AUIPC, 1, 0, V_DEC);
    cyc("auipc.upper",  1, AUIPC, 1, 0, V_AUIPC);
    cyc("auipc.wb",     1, AUIPC, 1, 0, V_ALUWB);

    cyc("addi.fetch",  1, ADDI, 1, 0, V_FRDY);
    cyc("addi.decode", 1, ADDI, 1, 0, V_DEC);
    cyc("addi.exec",   1, ADDI, 1, 0, V_EXI);
    cyc("addi.wb",     1, ADDI, 1, 0, V_ALUWB);

    // SW with mem_ready high: 4 cycles, back to fetch
    cyc("sw.fetch",  1, SW, 1, 0, V_FRDY);
    cyc("sw.decode", 1, SW, 1, 0, V_DEC);
    cyc("sw.memadr", 1, SW, 1, 0, V_MEMADR);
    cyc("sw.write",  1, SW, 1, 0, V_MEMWR);

    // Illegal opcode: absorbing trap, no memory traffic
    cyc("ill.fetch",  1, 7'h00, 1, 0, V_FRDY);
    cyc("ill.decode", 1, 7'h00, 1, 0, V_DEC);
    for (int i = 0; i < 20; i++)
      cyc($sformatf("ill.trap%0d", i), 1, 7'($urandom), 1'($urandom), 1'($urandom), V_TRAP);
    cyc("ill.reset",   0, 7'h00, 1, 0, V_ZERO);
    cyc("ill.release", 1, ADD, 0, 0, V_FWAIT, 1'b0);
    cyc("ill.fetch2",  1, ADD, 1, 0, V_FRDY);
    cyc("ill.decode2", 1, ADD, 1, 0, V_DEC);
    cyc("ill.exec2",   1, ADD, 1, 0, V_EXR);
    cyc("ill.wb2",     1, ADD, 1, 0, V_ALUWB);

    // Reset while a store is stalled in MEMWRITE
    cyc("swr.fetch",  1, SW, 1, 0, V_FRDY);
    cyc("swr.decode", 1, SW, 1, 0, V_DEC);
    cyc("swr.memadr", 1, SW, 1, 0, V_MEMADR);
    cyc("swr.wait",   1, SW, 0, 0, V_MEMWR);
    cyc("swr.reset0", 0, SW, 0, 0, V_ZERO);
    cyc("swr.reset1", 0, SW, 1, 0, V_ZERO);
    cyc("swr.release", 1, ADD, 1, 0, V_FRDY);
    cyc("swr.decode2", 1, ADD, 1, 0, V_DEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
